// File: rtl/risc_v_mike_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_mike_pkg
// Shared types and constants for the multi-cycle RISC-V core.
// Contents used by the memory arbiter:
//   DATA_32_W        data/address width of the core buses
//   MEM_ARB_LAT_W    width of the arbiter latency counter
//   mem_arb_state_t  arbiter FSM states (ARB_IDLE, ARB_BUSY)
//   mem_arb_owner_t  identity of the bus owner (OWNER_IFU, OWNER_LSU)
// -----------------------------------------------------------------------------
package risc_v_mike_pkg;

   localparam int DATA_32_W     = 32;
   localparam int MEM_ARB_LAT_W = 3;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } mem_arb_state_t;

   typedef enum logic {
      OWNER_IFU,
      OWNER_LSU
   } mem_arb_owner_t;

endpackage : risc_v_mike_pkg

// File: rtl/risc_v_rr_arb2.sv
// -----------------------------------------------------------------------------
// risc_v_rr_arb2
// Combinational two-way round-robin grant.
// Ports:
//   req_i[1:0]     request vector, bit 0 = IFU, bit 1 = LSU
//   last_owner_i   requester granted most recently (mem_arb_owner_t encoding)
//   enable_i       grants may only be issued while high
//   gnt_o[1:0]     one-hot grant (all zero when disabled or no request)
// -----------------------------------------------------------------------------
module risc_v_rr_arb2
   import risc_v_mike_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_owner_i,
   input  logic       enable_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (enable_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Contention: whoever did not own the bus last time wins.
            2'b11:   gnt_o = (last_owner_i == OWNER_LSU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

endmodule : risc_v_rr_arb2

// File: rtl/risc_v_mem_arbiter.sv
// -----------------------------------------------------------------------------
// risc_v_mem_arbiter
// Shares the single memory bus between the instruction-fetch unit (IFU) and the
// load/store unit (LSU). One access at a time, round-robin on contention, each
// access holds the bus for MEM_LATENCY cycles, then a one-cycle rvalid pulse
// returns data (or a write acknowledge) to the owner.
// Parameters:
//   MEM_LATENCY      bus cycles per access, 1..7
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ifu_req/addr     IFU read request and byte address
//   ifu_gnt          IFU request accepted this cycle (combinational)
//   ifu_rvalid/rdata IFU read return
//   lsu_req/we/addr/wdata  LSU access request
//   lsu_gnt          LSU request accepted this cycle (combinational)
//   lsu_rvalid/rdata LSU return (rdata is 0 for a write)
//   mem_bus_*        registered bus address/data and strobes, read data in
//   busy             high while an access occupies the bus
// -----------------------------------------------------------------------------
module risc_v_mem_arbiter
   import risc_v_mike_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 ifu_req,
   input  logic [DATA_32_W-1:0] ifu_addr,
   output logic                 ifu_gnt,
   output logic                 ifu_rvalid,
   output logic [DATA_32_W-1:0] ifu_rdata,

   input  logic                 lsu_req,
   input  logic                 lsu_we,
   input  logic [DATA_32_W-1:0] lsu_addr,
   input  logic [DATA_32_W-1:0] lsu_wdata,
   output logic                 lsu_gnt,
   output logic                 lsu_rvalid,
   output logic [DATA_32_W-1:0] lsu_rdata,

   output logic [DATA_32_W-1:0] mem_bus_rd_addr,
   output logic [DATA_32_W-1:0] mem_bus_wr_addr,
   output logic                 mem_bus_read,
   output logic                 mem_bus_write,
   output logic [DATA_32_W-1:0] mem_bus_wr_data,
   input  logic [DATA_32_W-1:0] mem_bus_rd_data,

   output logic                 busy
);

   // Counter value loaded on grant; reaching zero marks the last bus cycle.
   localparam logic [MEM_ARB_LAT_W-1:0] LAT_RELOAD = MEM_ARB_LAT_W'(MEM_LATENCY - 1);

   mem_arb_state_t             state_q, state_d;
   mem_arb_owner_t             owner_q, owner_d;
   mem_arb_owner_t             last_owner_q, last_owner_d;
   logic [MEM_ARB_LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic [DATA_32_W-1:0]       addr_q, addr_d;
   logic [DATA_32_W-1:0]       wdata_q, wdata_d;
   logic                       we_q, we_d;
   logic                       ifu_rvalid_q, ifu_rvalid_d;
   logic                       lsu_rvalid_q, lsu_rvalid_d;
   logic [DATA_32_W-1:0]       ifu_rdata_q, ifu_rdata_d;
   logic [DATA_32_W-1:0]       lsu_rdata_q, lsu_rdata_d;

   logic [1:0]                 req;
   logic [1:0]                 gnt;
   logic                       arb_en;
   logic                       grant;
   logic                       in_busy;

   assign req     = {lsu_req, ifu_req};
   // Gating with rst_n keeps grants low while reset is held.
   assign arb_en  = (state_q == ARB_IDLE) && rst_n;
   assign grant   = |gnt;
   assign in_busy = (state_q == ARB_BUSY);

   risc_v_rr_arb2 u_rr_arb2 (
      .req_i        (req),
      .last_owner_i (last_owner_q),
      .enable_i     (arb_en),
      .gnt_o        (gnt)
   );

   // Next-state, access capture and return path.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      lat_cnt_d    = lat_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      ifu_rvalid_d = 1'b0;
      lsu_rvalid_d = 1'b0;
      ifu_rdata_d  = ifu_rdata_q;
      lsu_rdata_d  = lsu_rdata_q;

      case (state_q)
         ARB_IDLE: begin
            if (grant) begin
               state_d   = ARB_BUSY;
               lat_cnt_d = LAT_RELOAD;
               if (gnt[1]) begin
                  owner_d      = OWNER_LSU;
                  last_owner_d = OWNER_LSU;
                  addr_d       = lsu_addr;
                  we_d         = lsu_we;
                  wdata_d      = lsu_wdata;
               end else begin
                  // The IFU only reads, so write enable and data are forced to 0.
                  owner_d      = OWNER_IFU;
                  last_owner_d = OWNER_IFU;
                  addr_d       = ifu_addr;
                  we_d         = 1'b0;
                  wdata_d      = '0;
               end
            end
         end
         ARB_BUSY: begin
            if (lat_cnt_q == '0) begin
               state_d = ARB_IDLE;
               // Only the owner's return registers change; a write returns 0.
               if (owner_q == OWNER_IFU) begin
                  ifu_rvalid_d = 1'b1;
                  ifu_rdata_d  = we_q ? '0 : mem_bus_rd_data;
               end else begin
                  lsu_rvalid_d = 1'b1;
                  lsu_rdata_d  = we_q ? '0 : mem_bus_rd_data;
               end
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWNER_LSU;
         last_owner_q <= OWNER_LSU;
         lat_cnt_q    <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         ifu_rvalid_q <= 1'b0;
         lsu_rvalid_q <= 1'b0;
         ifu_rdata_q  <= '0;
         lsu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         lat_cnt_q    <= lat_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         ifu_rvalid_q <= ifu_rvalid_d;
         lsu_rvalid_q <= lsu_rvalid_d;
         ifu_rdata_q  <= ifu_rdata_d;
         lsu_rdata_q  <= lsu_rdata_d;
      end
   end

   assign ifu_gnt         = gnt[0];
   assign lsu_gnt         = gnt[1];
   assign ifu_rvalid      = ifu_rvalid_q;
   assign ifu_rdata       = ifu_rdata_q;
   assign lsu_rvalid      = lsu_rvalid_q;
   assign lsu_rdata       = lsu_rdata_q;
   assign busy            = in_busy;

   assign mem_bus_rd_addr = addr_q;
   assign mem_bus_wr_addr = addr_q;
   assign mem_bus_wr_data = wdata_q;
   assign mem_bus_read    = in_busy && !we_q;
   // The counter still holds its reload value only in the first busy cycle,
   // which gives the memory controller a single write edge.
   assign mem_bus_write   = in_busy && we_q && (lat_cnt_q == LAT_RELOAD);

endmodule : risc_v_mem_arbiter

// File: tb/tb_risc_v_mem_arbiter.sv
module tb_risc_v_mem_arbiter;

   localparam int N = 3;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
   endfunction

   logic        clk;
   logic        rst_n;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [31:0] mem_bus_rd_data;

   logic [N-1:0]       ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid;
   logic [N-1:0]       mem_bus_read, mem_bus_write, busy;
   logic [N-1:0][31:0] ifu_rdata, lsu_rdata, rd_addr, wr_addr, wr_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      risc_v_mem_arbiter #(.MEM_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .ifu_req         (ifu_req),
         .ifu_addr        (ifu_addr),
         .ifu_gnt         (ifu_gnt[g]),
         .ifu_rvalid      (ifu_rvalid[g]),
         .ifu_rdata       (ifu_rdata[g]),
         .lsu_req         (lsu_req),
         .lsu_we          (lsu_we),
         .lsu_addr        (lsu_addr),
         .lsu_wdata       (lsu_wdata),
         .lsu_gnt         (lsu_gnt[g]),
         .lsu_rvalid      (lsu_rvalid[g]),
         .lsu_rdata       (lsu_rdata[g]),
         .mem_bus_rd_addr (rd_addr[g]),
         .mem_bus_wr_addr (wr_addr[g]),
         .mem_bus_read    (mem_bus_read[g]),
         .mem_bus_write   (mem_bus_write[g]),
         .mem_bus_wr_data (wr_data[g]),
         .mem_bus_rd_data (mem_bus_rd_data),
         .busy            (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] cycle %0d: got %b expected %b", nm, idx, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] cycle %0d: got 0x%08h expected 0x%08h", nm, idx, cyc, act, exp);
      end
   endtask

   // Transaction-level model: each grant opens an access starting at cycle S;
   // the bus is busy for cycles S+1..S+L and the return arrives at S+L+1.
   bit          m_valid [N];
   int          m_start [N];
   bit          m_owner [N];   // 0 = IFU, 1 = LSU
   bit          m_we    [N];
   bit          m_last  [N];
   logic [31:0] m_addr  [N];
   logic [31:0] m_wdata [N];
   logic [31:0] m_pend  [N];
   logic [31:0] m_ifu_rd[N];
   logic [31:0] m_lsu_rd[N];

   always @(negedge clk) begin
      int L;
      bit bz, rv, ig, lg;
      for (int k = 0; k < N; k++) begin
         if (!rst_n) begin
            m_valid[k]  = 1'b0;
            m_last[k]   = 1'b1;
            m_addr[k]   = '0;
            m_wdata[k]  = '0;
            m_ifu_rd[k] = '0;
            m_lsu_rd[k] = '0;
            chk1("rst_busy", k, busy[k], 1'b0);
            chk1("rst_ifu_gnt", k, ifu_gnt[k], 1'b0);
            chk1("rst_lsu_gnt", k, lsu_gnt[k], 1'b0);
            chk1("rst_read", k, mem_bus_read[k], 1'b0);
            chk1("rst_write", k, mem_bus_write[k], 1'b0);
            chk1("rst_ifu_rvalid", k, ifu_rvalid[k], 1'b0);
            chk1("rst_lsu_rvalid", k, lsu_rvalid[k], 1'b0);
            chk32("rst_ifu_rdata", k, ifu_rdata[k], 32'h0);
            chk32("rst_lsu_rdata", k, lsu_rdata[k], 32'h0);
            chk32("rst_rd_addr", k, rd_addr[k], 32'h0);
            chk32("rst_wr_data", k, wr_data[k], 32'h0);
         end else begin
            L  = lat_of(k);
            bz = m_valid[k] && (cyc >= m_start[k] + 1) && (cyc <= m_start[k] + L);
            rv = m_valid[k] && (cyc == m_start[k] + L + 1);
            if (m_valid[k] && cyc == m_start[k] + L)
               m_pend[k] = m_we[k] ? 32'h0 : mem_bus_rd_data;
            if (rv) begin
               if (m_owner[k]) m_lsu_rd[k] = m_pend[k];
               else            m_ifu_rd[k] = m_pend[k];
            end
            ig = !bz && ifu_req && (!lsu_req || m_last[k]);
            lg = !bz && lsu_req && (!ifu_req || !m_last[k]);

            chk1("busy", k, busy[k], bz);
            chk1("ifu_gnt", k, ifu_gnt[k], ig);
            chk1("lsu_gnt", k, lsu_gnt[k], lg);
            chk1("read", k, mem_bus_read[k], bz && !m_we[k]);
            chk1("write", k, mem_bus_write[k], bz && m_we[k] && (cyc == m_start[k] + 1));
            chk1("ifu_rvalid", k, ifu_rvalid[k], rv && !m_owner[k]);
            chk1("lsu_rvalid", k, lsu_rvalid[k], rv && m_owner[k]);
            chk32("ifu_rdata", k, ifu_rdata[k], m_ifu_rd[k]);
            chk32("lsu_rdata", k, lsu_rdata[k], m_lsu_rd[k]);
            chk32("rd_addr", k, rd_addr[k], m_addr[k]);
            chk32("wr_addr", k, wr_addr[k], m_addr[k]);
            chk32("wr_data", k, wr_data[k], m_wdata[k]);

            if (ig || lg) begin
               m_valid[k] = 1'b1;
               m_start[k] = cyc;
               m_owner[k] = lg;
               m_we[k]    = lg && lsu_we;
               m_addr[k]  = lg ? lsu_addr : ifu_addr;
               m_wdata[k] = lg ? lsu_wdata : 32'h0;
               m_last[k]  = lg;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      ifu_req = 1'b0;
      lsu_req = 1'b0;
      lsu_we  = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      ifu_req         = 1'b0;
      ifu_addr        = '0;
      lsu_req         = 1'b0;
      lsu_we          = 1'b0;
      lsu_addr        = '0;
      lsu_wdata       = '0;
      mem_bus_rd_data = '0;
      step();
      step();
      rst_n = 1'b1;
      idle(2);

      // IFU read, latency 1 (instance 0).
      ifu_req = 1'b1; ifu_addr = 32'h0040_0000; mem_bus_rd_data = 32'h0050_0093;
      @(negedge clk);
      chk1("t1_ifu_gnt_T", 0, ifu_gnt[0], 1'b1);
      chk1("t1_read_T", 0, mem_bus_read[0], 1'b0);
      step(); ifu_req = 1'b0;
      @(negedge clk);
      chk1("t1_read_T1", 0, mem_bus_read[0], 1'b1);
      chk32("t1_rd_addr_T1", 0, rd_addr[0], 32'h0040_0000);
      step();
      @(negedge clk);
      chk1("t1_ifu_rvalid_T2", 0, ifu_rvalid[0], 1'b1);
      chk32("t1_ifu_rdata_T2", 0, ifu_rdata[0], 32'h0050_0093);
      chk1("t1_lsu_rvalid_T2", 0, lsu_rvalid[0], 1'b0);
      chk1("t1_busy_T2", 0, busy[0], 1'b0);
      idle(8);

      // LSU write, latency 3 (instance 1).
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h1001_0004; lsu_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk1("t2_lsu_gnt_T", 1, lsu_gnt[1], 1'b1);
      for (int j = 1; j <= 4; j++) begin
         step();
         lsu_req = 1'b0; lsu_we = 1'b0;
         @(negedge clk);
         chk1("t2_write", 1, mem_bus_write[1], j == 1);
         chk1("t2_busy", 1, busy[1], j <= 3);
         chk1("t2_lsu_rvalid", 1, lsu_rvalid[1], j == 4);
         chk32("t2_wr_addr", 1, wr_addr[1], 32'h1001_0004);
      end
      chk32("t2_lsu_rdata", 1, lsu_rdata[1], 32'h0);
      chk32("t2_wr_data", 1, wr_data[1], 32'hDEAD_BEEF);
      idle(8);

      // Continuous contention from reset, latency 3: IFU@0, LSU@4, IFU@8.
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1; ifu_req = 1'b1; lsu_req = 1'b1; lsu_we = 1'b0;
      ifu_addr = 32'h0040_0010; lsu_addr = 32'h1001_0020;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) step();
         mem_bus_rd_data = 32'hC0DE_0000 + 32'(i);
         @(negedge clk);
         chk1("t3_ifu_gnt", 1, ifu_gnt[1], (i == 0) || (i == 8));
         chk1("t3_lsu_gnt", 1, lsu_gnt[1], i == 4);
      end
      step();
      idle(8);

      // LSU alone, back-to-back loads, latency 1 (instance 0): grants at 0,2,4.
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h1001_0100;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         mem_bus_rd_data = 32'h1111_0000 + 32'(i);
         @(negedge clk);
         chk1("t4_lsu_gnt", 0, lsu_gnt[0], (i % 2) == 0);
         chk1("t4_ifu_gnt", 0, ifu_gnt[0], 1'b0);
         if (i == 2) chk32("t4_lsu_rdata_a", 0, lsu_rdata[0], 32'h1111_0001);
         if (i == 4) chk32("t4_lsu_rdata_b", 0, lsu_rdata[0], 32'h1111_0003);
      end
      step();
      idle(8);

      // Reset in the middle of a latency-4 LSU read (instance 2).
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h7FFF_EFF0; mem_bus_rd_data = 32'h2222_2222;
      @(negedge clk);
      chk1("t5_lsu_gnt_T", 2, lsu_gnt[2], 1'b1);
      step(); lsu_req = 1'b0;
      @(negedge clk);
      chk1("t5_read_T1", 2, mem_bus_read[2], 1'b1);
      step(); rst_n = 1'b0;
      @(negedge clk);
      chk1("t5_read_rst", 2, mem_bus_read[2], 1'b0);
      chk1("t5_busy_rst", 2, busy[2], 1'b0);
      step(); rst_n = 1'b1; ifu_req = 1'b1; lsu_req = 1'b1; ifu_addr = 32'h0040_0040;
      @(negedge clk);
      chk1("t5_ifu_first", 2, ifu_gnt[2], 1'b1);
      chk1("t5_lsu_not_first", 2, lsu_gnt[2], 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(); ifu_req = 1'b0; lsu_req = 1'b0;
         @(negedge clk);
         chk1("t5_no_lsu_rvalid", 2, lsu_rvalid[2], 1'b0);
      end
      idle(8);

      // LSU drops its request while the IFU is serviced, latency 3 (instance 1).
      ifu_req = 1'b1; ifu_addr = 32'h0040_0080;
      @(negedge clk);
      chk1("t6_ifu_gnt", 1, ifu_gnt[1], 1'b1);
      for (int i = 1; i <= 5; i++) begin
         step();
         ifu_req = 1'b0;
         lsu_req = (i <= 2);
         lsu_addr = 32'h1001_0200;
         @(negedge clk);
         chk1("t6_no_lsu_gnt", 1, lsu_gnt[1], 1'b0);
      end
      idle(2);
      // Last owner is now IFU, so contention goes to the LSU.
      ifu_req = 1'b1; lsu_req = 1'b1;
      @(negedge clk);
      chk1("t6_rr_lsu", 1, lsu_gnt[1], 1'b1);
      chk1("t6_rr_ifu", 1, ifu_gnt[1], 1'b0);
      step();
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_risc_v_mem_arbiter
